// File: rtl/adder2_sweep_checker.sv
// Exhaustive sweep checker for a 2-bit adder netlist.
// Drives all 16 {a1,a0,b1,b0} combinations in ascending order, waits SETTLE
// extra cycles per vector, samples {c1,s1,s0} and compares against a + b.
module adder2_sweep_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dut_s0,
    input  logic        dut_s1,
    input  logic        dut_c1,
    output logic        a0,
    output logic        a1,
    output logic        b0,
    output logic        b1,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [15:0] mismatch_mask,
    output logic [3:0]  first_fail_vec,
    output logic [2:0]  first_fail_got,
    output logic        first_fail_valid
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StCheck  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [3:0] SettleCnt = 4'(SETTLE);

    logic [1:0] state;
    logic [3:0] vec;
    logic [3:0] cnt;
    logic [3:0] opnd;
    logic [2:0] got;
    logic [2:0] exp_sum;
    logic       mismatch;

    // Golden sum is derived from the vector index, which always equals the driven operands.
    always_comb begin
        got      = {dut_c1, dut_s1, dut_s0};
        exp_sum  = {1'b0, vec[3:2]} + {1'b0, vec[1:0]};
        mismatch = (got != exp_sum);
    end

    // Sweep sequencer plus result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= StIdle;
            vec              <= 4'd0;
            cnt              <= 4'd0;
            opnd             <= 4'd0;
            err_count        <= 5'd0;
            mismatch_mask    <= 16'd0;
            first_fail_vec   <= 4'd0;
            first_fail_got   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state            <= StSettle;
                        vec              <= 4'd0;
                        cnt              <= SettleCnt;
                        opnd             <= 4'd0;
                        err_count        <= 5'd0;
                        mismatch_mask    <= 16'd0;
                        first_fail_vec   <= 4'd0;
                        first_fail_got   <= 3'd0;
                        first_fail_valid <= 1'b0;
                    end
                end
                StSettle: begin
                    if (cnt == 4'd0) begin
                        state <= StCheck;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_count          <= err_count + 5'd1;
                        mismatch_mask[vec] <= 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec;
                            first_fail_got   <= got;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (vec == 4'd15) begin
                        state <= StDone;
                        opnd  <= 4'd0;
                    end else begin
                        state <= StSettle;
                        vec   <= vec + 4'd1;
                        opnd  <= vec + 4'd1;
                        cnt   <= SettleCnt;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        {a1, a0, b1, b0} = opnd;
        busy             = (state == StSettle) || (state == StCheck);
        done             = (state == StDone);
        pass             = done && (err_count == 5'd0);
    end

endmodule

// File: tb/tb_adder2_sweep_checker.sv
// Scoreboard bench for adder2_sweep_checker: one SETTLE=1 instance checked via a
// result queue, one SETTLE=0 instance checked for operand sequence and start hold.
module tb_adder2_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start0 = 1'b0;
    int   fault = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // fault: 0 correct adder, 1 c1 stuck at 0, 2 s0 inverted
    function automatic logic [2:0] model(input logic [3:0] v, input int f);
        logic [2:0] s;
        s = {1'b0, v[3:2]} + {1'b0, v[1:0]};
        if (f == 1) s[2] = 1'b0;
        else if (f == 2) s[0] = ~s[0];
        return s;
    endfunction

    logic u1_a0, u1_a1, u1_b0, u1_b1, u1_s0, u1_s1, u1_c1;
    logic u1_busy, u1_done, u1_pass, u1_ffv;
    logic [4:0] u1_ec;
    logic [15:0] u1_mask;
    logic [3:0] u1_fv;
    logic [2:0] u1_fg;
    logic [3:0] op1;
    assign op1 = {u1_a1, u1_a0, u1_b1, u1_b0};
    assign {u1_c1, u1_s1, u1_s0} = model(op1, fault);

    logic u0_a0, u0_a1, u0_b0, u0_b1, u0_s0, u0_s1, u0_c1;
    logic u0_busy, u0_done, u0_pass, u0_ffv;
    logic [4:0] u0_ec;
    logic [15:0] u0_mask;
    logic [3:0] u0_fv;
    logic [2:0] u0_fg;
    logic [3:0] op0;
    assign op0 = {u0_a1, u0_a0, u0_b1, u0_b0};
    assign {u0_c1, u0_s1, u0_s0} = model(op0, fault);

    adder2_sweep_checker #(.SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .dut_s0(u1_s0), .dut_s1(u1_s1), .dut_c1(u1_c1),
        .a0(u1_a0), .a1(u1_a1), .b0(u1_b0), .b1(u1_b1),
        .busy(u1_busy), .done(u1_done), .pass(u1_pass),
        .err_count(u1_ec), .mismatch_mask(u1_mask),
        .first_fail_vec(u1_fv), .first_fail_got(u1_fg), .first_fail_valid(u1_ffv)
    );

    adder2_sweep_checker #(.SETTLE(0)) u0 (
        .clk(clk), .rst(rst), .start(start0),
        .dut_s0(u0_s0), .dut_s1(u0_s1), .dut_c1(u0_c1),
        .a0(u0_a0), .a1(u0_a1), .b0(u0_b0), .b1(u0_b1),
        .busy(u0_busy), .done(u0_done), .pass(u0_pass),
        .err_count(u0_ec), .mismatch_mask(u0_mask),
        .first_fail_vec(u0_fv), .first_fail_got(u0_fg), .first_fail_valid(u0_ffv)
    );

    typedef struct {
        int lat;
        int ec;
        int mask;
        int fv;
        int fg;
        int fvalid;
        int pass;
    } exp_t;

    exp_t sb[$];
    int   t0 = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Monitor: on each rising done of the SETTLE=1 instance, pop and compare.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (u1_done && !prev_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc - t0, e.lat);
                    chk("err_count", int'(u1_ec), e.ec);
                    chk("mismatch_mask", int'(u1_mask), e.mask);
                    chk("first_fail_vec", int'(u1_fv), e.fv);
                    chk("first_fail_got", int'(u1_fg), e.fg);
                    chk("first_fail_valid", int'(u1_ffv), e.fvalid);
                    chk("pass", int'(u1_pass), e.pass);
                    chk("busy_at_done", int'(u1_busy), 0);
                end
                done_cnt++;
            end
            prev_done = u1_done;
        end
    end

    task automatic issue(input int f, input exp_t e, input bit push);
        @(negedge clk);
        fault = f;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start1 = 1'b0;
        if (push) sb.push_back(e);
    endtask

    task automatic wait_done();
        int d;
        int i;
        d = done_cnt;
        i = 0;
        while (done_cnt == d && i < 300) begin
            @(negedge clk);
            i++;
        end
        #1;
        if (done_cnt == d) chk("done_timeout", done_cnt - d, 1);
    endtask

    task automatic chk_zero_u1(input string tag);
        chk({tag, "_operands"}, int'(op1), 0);
        chk({tag, "_busy"}, int'(u1_busy), 0);
        chk({tag, "_done"}, int'(u1_done), 0);
        chk({tag, "_pass"}, int'(u1_pass), 0);
        chk({tag, "_err_count"}, int'(u1_ec), 0);
        chk({tag, "_mask"}, int'(u1_mask), 0);
        chk({tag, "_ff_vec"}, int'(u1_fv), 0);
        chk({tag, "_ff_got"}, int'(u1_fg), 0);
        chk({tag, "_ff_valid"}, int'(u1_ffv), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t good, c1_stuck, s0_inv;
        good     = '{48, 0, 0, 0, 0, 0, 1};
        c1_stuck = '{48, 6, 'hEC80, 7, 0, 1, 0};
        s0_inv   = '{48, 16, 'hFFFF, 0, 1, 1, 0};

        // Reset state
        #1;
        chk_zero_u1("reset");
        chk("reset_u0_done", int'(u0_done), 0);
        chk("reset_u0_busy", int'(u0_busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Main function across fault patterns
        issue(0, good, 1'b1);
        chk("busy_after_start", int'(u1_busy), 1);
        wait_done();
        issue(1, c1_stuck, 1'b1);
        wait_done();
        issue(2, s0_inv, 1'b1);
        wait_done();

        // start pulsed mid-sweep is ignored
        issue(0, good, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done();

        // Async reset mid-sweep with s0 inverted: six vectors already failed
        issue(2, good, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("pre_rst_err_count", int'(u1_ec), 6);
        chk("pre_rst_mask", int'(u1_mask), 'h003F);
        chk("pre_rst_busy", int'(u1_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero_u1("midrst");
        @(negedge clk);
        rst = 1'b0;
        issue(0, good, 1'b1);
        wait_done();

        // SETTLE=0: operand sequence, done at E0+32, start held high restarts
        @(negedge clk);
        fault = 0;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            chk("u0_operand_seq", int'(op0), k);
            if (k == 15) chk("u0_done_early", int'(u0_done), 0);
            repeat (2) @(posedge clk);
            #1;
        end
        chk("u0_done", int'(u0_done), 1);
        chk("u0_pass", int'(u0_pass), 1);
        chk("u0_err_count", int'(u0_ec), 0);
        @(posedge clk);
        #1;
        chk("u0_restart_done", int'(u0_done), 0);
        chk("u0_restart_busy", int'(u0_busy), 1);
        start0 = 1'b0;

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
